ram_port_arbiter: RTL and testbench
===================================

# ram_port_arbiter

Shares the single-port data RAM of the approximate-multiplier datapath between three requesters: host loader (port 0), operand fetch engine (port 1) and result writer (port 2). It grants at most one access per cycle using round-robin priority, supports locked bursts so a requester can keep the RAM for consecutive accesses, and returns read data tagged to the requester one cycle after its read grant. It sits between the datapath controller's engines and the RAM macro.

## Interface
- ADDR_W, 4, RAM address width
- DATA_W, 16, RAM word width
- MAX_BURST, 4, maximum consecutive grants under lock (>=1)

- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- req  in  3  per-port access request, bit i = port i
- we  in  3  per-port write enable (1 = write, 0 = read), sampled with req
- lock  in  3  per-port burst lock request
- addr  in  3*ADDR_W  per-port address, port i at [i*ADDR_W +: ADDR_W]
- wdata  in  3*DATA_W  per-port write data, port i at [i*DATA_W +: DATA_W]
- gnt  out  3  one-hot grant (combinational); access occurs at the edge ending a cycle with req[i]&gnt[i]
- rvalid  out  3  registered, one-hot read-data-valid tag
- rdata  out  DATA_W  read data, pass-through of ram_rdata
- ram_en  out  1  RAM enable (= |gnt)
- ram_we  out  1  RAM write enable of granted port
- ram_addr  out  ADDR_W  address of granted port
- ram_wdata  out  DATA_W  write data of granted port
- ram_rdata  in  DATA_W  RAM read data, valid one cycle after a read enable

## Operation
- Registers: state {FREE, LOCKED}, owner (2 bits), last (2 bits, last granted port), burst_cnt (clog2(MAX_BURST+1) bits), rvalid.
- Reset values: state=FREE, owner=0, last=2 (so port 0 has first priority), burst_cnt=0, rvalid=000; gnt forced 000 while rst high; ram_en=0.
- FREE: priority order (last+1), (last+2), (last+3) mod 3; grant first requesting port in that order. On grant: last<=granted index. If lock[idx]=1 and MAX_BURST>1: state<=LOCKED, owner<=idx, burst_cnt<=1.
- LOCKED: only owner may be granted; other requests are held off (gnt=000 for them).
  - owner req=1: grant it, burst_cnt+1; if new burst_cnt==MAX_BURST or lock[owner]=0 in that cycle, state<=FREE after this access.
  - owner req=0, lock[owner]=1: idle cycle, gnt=000, burst_cnt unchanged, stay LOCKED.
  - lock[owner]=0 and req[owner]=0: state<=FREE, no grant this cycle.
- last is updated on every grant, including inside a burst.
- RAM muxing: ram_we/ram_addr/ram_wdata select the granted port's fields; when gnt=000 outputs are ram_en=0, others 0.
- Read return: rvalid <= gnt & ~we & req (registered); rdata = ram_rdata. Writes produce no rvalid.
- Requesters must hold req, we, addr, wdata, lock stable until granted; dropping req before grant is legal (request withdrawn).
- Write followed by read of same address in the next cycle returns the new data (RAM write-first at edge).

## Timing
- Grant latency: 0 cycles (gnt combinational from req and registered state); no combinational path from gnt back to req permitted in requesters.
- Throughput: one access per cycle, back-to-back grants to same or different ports allowed.
- Read latency: rvalid[i] and valid rdata exactly 1 cycle after the read grant cycle; pipelined reads yield rvalid every cycle.
- Lock release takes effect for arbitration in the cycle after the last locked grant.
- Reset mid-burst: state returns to FREE, pending rvalid cleared immediately (async); first arbitration after release starts from port 0.
- MAX_BURST=1: lock ignored, pure round-robin.

## Test plan
- Reset, RAM[3]=0x00A5, req=001 we=0 addr0=3 -> gnt=001 same cycle, next cycle rvalid=001, rdata=0x00A5.
- req=111 held, lock=000, all reads -> gnt sequence 001,010,100,001,010,100; rvalid follows one cycle later.
- req=111, lock=010 held, MAX_BURST=4 -> after port 1 first granted, gnt=010 for 4 consecutive cycles, then 100, then 001.
- Port 1 locked, drops req for 2 cycles with lock=1 while req0=1 -> gnt=000 both cycles; port 1 re-asserts -> gnt=010, burst_cnt continues.
- Port 2 writes 0x1234 to addr 7, next cycle port 0 reads addr 7 -> rvalid=001 with rdata=0x1234.
- rst pulsed during a locked burst of port 2 with req=111 -> gnt=000, rvalid=000 during rst; first cycle after release gnt=001.

Source files
------------

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one single-port data RAM between three requesters,
// with locked bursts and tagged read-data return one cycle after the read grant.
module ram_port_arbiter #(
  parameter int ADDR_W    = 4,
  parameter int DATA_W    = 16,
  parameter int MAX_BURST = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [2:0]          req,
  input  logic [2:0]          we,
  input  logic [2:0]          lock,
  input  logic [3*ADDR_W-1:0] addr,
  input  logic [3*DATA_W-1:0] wdata,
  output logic [2:0]          gnt,
  output logic [2:0]          rvalid,
  output logic [DATA_W-1:0]   rdata,
  output logic                ram_en,
  output logic                ram_we,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic [DATA_W-1:0]   ram_wdata,
  input  logic [DATA_W-1:0]   ram_rdata
);

  localparam int BW = $clog2(MAX_BURST + 1);

  typedef enum logic {FREE, LOCKED} state_t;

  state_t        state;
  logic [1:0]    owner;
  logic [1:0]    last;
  logic [BW-1:0] burst_cnt;
  logic [BW-1:0] burst_nxt;
  logic [2:0]    gnt_c;
  logic [1:0]    gidx;
  logic [1:0]    p1, p2, p3;

  function automatic logic [1:0] nxt_port(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  always_comb begin
    gnt_c = 3'b000;
    gidx  = 2'd0;
    p1    = nxt_port(last);
    p2    = nxt_port(p1);
    p3    = nxt_port(p2);
    if (state == FREE) begin
      if (req[p1]) begin
        gidx = p1;
        gnt_c[p1] = 1'b1;
      end else if (req[p2]) begin
        gidx = p2;
        gnt_c[p2] = 1'b1;
      end else if (req[p3]) begin
        gidx = p3;
        gnt_c[p3] = 1'b1;
      end
    end else if (req[owner]) begin
      gidx = owner;
      gnt_c[owner] = 1'b1;
    end
  end

  // Grant is suppressed during reset so nothing reaches the RAM while it is asserted.
  assign gnt       = rst ? 3'b000 : gnt_c;
  assign ram_en    = |gnt;
  assign ram_we    = ram_en ? we[gidx] : 1'b0;
  assign ram_addr  = ram_en ? addr[gidx*ADDR_W +: ADDR_W] : '0;
  assign ram_wdata = ram_en ? wdata[gidx*DATA_W +: DATA_W] : '0;
  assign rdata     = ram_rdata;
  assign burst_nxt = burst_cnt + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= FREE;
      owner     <= 2'd0;
      last      <= 2'd2;
      burst_cnt <= '0;
      rvalid    <= 3'b000;
    end else begin
      rvalid <= gnt & ~we & req;
      if (state == FREE) begin
        if (|gnt) begin
          last <= gidx;
          if (lock[gidx] && MAX_BURST > 1) begin
            state     <= LOCKED;
            owner     <= gidx;
            burst_cnt <= BW'(1);
          end
        end
      end else begin
        if (|gnt) begin
          last      <= owner;
          burst_cnt <= burst_nxt;
          if (burst_nxt == BW'(MAX_BURST) || !lock[owner]) begin
            state     <= FREE;
            burst_cnt <= '0;
          end
        end else if (!lock[owner]) begin
          state     <= FREE;
          burst_cnt <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter: round robin, locked bursts, read return,
// write-then-read forwarding through a behavioural RAM, and reset mid-burst.
module tb_ram_port_arbiter;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [2:0]        req = '0, we = '0, lock = '0;
  logic [ADDR_W-1:0] a0 = '0, a1 = '0, a2 = '0;
  logic [DATA_W-1:0] d0 = '0, d1 = '0, d2 = '0;
  logic [2:0]        gnt, rvalid;
  logic [DATA_W-1:0] rdata, ram_wdata, ram_rdata;
  logic              ram_en, ram_we;
  logic [ADDR_W-1:0] ram_addr;

  logic [DATA_W-1:0] mem [16];
  logic              ld_en = 1'b0;
  logic [ADDR_W-1:0] ld_addr = '0;
  logic [DATA_W-1:0] ld_data = '0;

  int tests = 0;
  int fails = 0;

  ram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BURST(4)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .lock(lock),
    .addr({a2, a1, a0}), .wdata({d2, d1, d0}),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ld_en) mem[ld_addr] <= ld_data;
    else if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else ram_rdata <= mem[ram_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Apply inputs at the falling edge and settle before checking.
  task automatic drive(input logic [2:0] r, input logic [2:0] w, input logic [2:0] l);
    @(negedge clk);
    req = r; we = w; lock = l;
    #1;
  endtask

  logic [2:0]        exp_g [6];
  logic [DATA_W-1:0] port_val [3];
  logic [2:0]        prev_g;

  initial begin
    port_val[0] = 16'h00A5; port_val[1] = 16'h1005; port_val[2] = 16'h1009;

    // Preload RAM while reset holds the arbiter off the bus.
    req = 3'b111;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      ld_en = 1'b1; ld_addr = ADDR_W'(i);
      ld_data = (i == 3) ? 16'h00A5 : 16'h1000 + 16'(i);
    end
    @(negedge clk);
    ld_en = 1'b0;
    #1;
    chk("rst_gnt", gnt, 3'b000);
    chk("rst_ram_en", ram_en, 1'b0);
    chk("rst_rvalid", rvalid, 3'b000);

    // Single read from port 0 after reset.
    a0 = 4'd3; a1 = 4'd5; a2 = 4'd9;
    @(negedge clk);
    rst = 1'b0;
    drive(3'b001, 3'b000, 3'b000);
    chk("rd_gnt", gnt, 3'b001);
    chk("rd_ram_addr", ram_addr, 4'd3);
    chk("rd_ram_en", ram_en, 1'b1);
    drive(3'b000, 3'b000, 3'b000);
    chk("rd_idle_gnt", gnt, 3'b000);
    chk("rd_rvalid", rvalid, 3'b001);
    chk("rd_rdata", rdata, 16'h00A5);

    // Round robin, last granted was port 0.
    exp_g[0] = 3'b010; exp_g[1] = 3'b100; exp_g[2] = 3'b001;
    exp_g[3] = 3'b010; exp_g[4] = 3'b100; exp_g[5] = 3'b001;
    prev_g = 3'b000;
    for (int i = 0; i < 6; i++) begin
      drive(3'b111, 3'b000, 3'b000);
      chk($sformatf("rr_gnt%0d", i), gnt, exp_g[i]);
      if (i > 0) begin
        chk($sformatf("rr_rvalid%0d", i), rvalid, prev_g);
        chk($sformatf("rr_rdata%0d", i), rdata,
            port_val[prev_g[0] ? 0 : (prev_g[1] ? 1 : 2)]);
      end
      prev_g = exp_g[i];
    end
    drive(3'b000, 3'b000, 3'b000);
    chk("rr_rvalid_last", rvalid, 3'b001);

    // Locked burst of port 1 capped at four grants.
    exp_g[0] = 3'b010; exp_g[1] = 3'b010; exp_g[2] = 3'b010;
    exp_g[3] = 3'b010; exp_g[4] = 3'b100; exp_g[5] = 3'b001;
    for (int i = 0; i < 6; i++) begin
      drive(3'b111, 3'b000, 3'b010);
      chk($sformatf("burst_gnt%0d", i), gnt, exp_g[i]);
    end
    drive(3'b000, 3'b000, 3'b000);

    // Locked owner pauses; port 0 stays held off and the burst count resumes.
    drive(3'b011, 3'b000, 3'b010);
    chk("pause_gnt0", gnt, 3'b010);
    drive(3'b001, 3'b000, 3'b010);
    chk("pause_idle0", gnt, 3'b000);
    chk("pause_en0", ram_en, 1'b0);
    drive(3'b001, 3'b000, 3'b010);
    chk("pause_idle1", gnt, 3'b000);
    drive(3'b011, 3'b000, 3'b010);
    chk("pause_gnt1", gnt, 3'b010);
    drive(3'b011, 3'b000, 3'b010);
    chk("pause_gnt2", gnt, 3'b010);
    drive(3'b011, 3'b000, 3'b010);
    chk("pause_gnt3", gnt, 3'b010);
    drive(3'b011, 3'b000, 3'b010);
    chk("pause_release", gnt, 3'b001);
    drive(3'b000, 3'b000, 3'b000);

    // Write by port 2 then read-back by port 0.
    a2 = 4'd7; d2 = 16'h1234; a0 = 4'd7;
    drive(3'b100, 3'b100, 3'b000);
    chk("wr_gnt", gnt, 3'b100);
    chk("wr_ram_we", ram_we, 1'b1);
    chk("wr_ram_addr", ram_addr, 4'd7);
    chk("wr_ram_wdata", ram_wdata, 16'h1234);
    drive(3'b001, 3'b000, 3'b000);
    chk("wr_rd_gnt", gnt, 3'b001);
    chk("wr_no_rvalid", rvalid, 3'b000);
    drive(3'b000, 3'b000, 3'b000);
    chk("wr_rd_rvalid", rvalid, 3'b001);
    chk("wr_rd_rdata", rdata, 16'h1234);

    // Reset during a locked burst of port 2.
    drive(3'b100, 3'b000, 3'b100);
    chk("rb_gnt0", gnt, 3'b100);
    drive(3'b111, 3'b000, 3'b100);
    chk("rb_gnt1", gnt, 3'b100);
    chk("rb_rvalid", rvalid, 3'b100);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rb_rst_gnt", gnt, 3'b000);
    chk("rb_rst_rvalid", rvalid, 3'b000);
    chk("rb_rst_en", ram_en, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rb_after_gnt", gnt, 3'b001);
    drive(3'b000, 3'b000, 3'b000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
